// File: rtl/alu_pkg.sv
// Shared opcode and FSM-state definitions for the sequential ALU.
// Opcode values match the legacy ALU_* encodings used elsewhere in the codebase.
package alu_pkg;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_NOR  = 5'd5,
        ALU_SLL  = 5'd6,
        ALU_SRL  = 5'd7,
        ALU_SRA  = 5'd8,
        ALU_SLLV = 5'd9,
        ALU_SRLV = 5'd10,
        ALU_SRAV = 5'd11,
        ALU_EQ   = 5'd12,
        ALU_NEQ  = 5'd13,
        ALU_LT   = 5'd14,
        ALU_LE   = 5'd15,
        ALU_GT   = 5'd16,
        ALU_GE   = 5'd17,
        ALU_LUI  = 5'd18,
        ALU_MULT = 5'd19,
        ALU_DIV  = 5'd20
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_seq_state_t;

    // Two's-complement overflow: operands share a sign the result does not.
    function automatic logic signed_overflow(input logic x_msb, input logic y_msb, input logic r_msb);
        return (x_msb == y_msb) && (r_msb != x_msb);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier and (with ALU_SEQ_DIV_EN) restoring divider.
// One bit per cycle for WIDTH cycles through a single shared WIDTH-bit adder.
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef ALU_SEQ_DIV_EN
    input  logic             is_div,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] operand_b;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] cur_hi;
    logic [WIDTH-1:0] cur_lo;
    logic [WIDTH-1:0] cur_b;
    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic             add_cin;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;

`ifdef ALU_SEQ_DIV_EN
    logic div_mode;
    logic cur_div;
    logic fits;
    assign cur_div = start ? is_div : div_mode;
`endif

    // The start cycle already performs the first step on the raw operands, so
    // the final step lands WIDTH-1 edges later and the result is ready on the next.
    assign cur_hi = start ? '0 : acc_hi;
    assign cur_lo = start ? a  : acc_lo;
    assign cur_b  = start ? b  : operand_b;

    assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};

    always_comb begin
        add_x   = cur_hi;
        add_y   = cur_lo[0] ? cur_b : '0;
        add_cin = 1'b0;
        nxt_hi  = {add_sum[WIDTH], add_sum[WIDTH-1:1]};
        nxt_lo  = {add_sum[0], cur_lo[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
        fits = 1'b0;
        if (cur_div) begin
            // Trial subtraction of the divisor from the left-shifted partial remainder.
            add_x   = {cur_hi[WIDTH-2:0], cur_lo[WIDTH-1]};
            add_y   = ~cur_b;
            add_cin = 1'b1;
            fits    = cur_hi[WIDTH-1] | add_sum[WIDTH];
            nxt_hi  = fits ? add_sum[WIDTH-1:0] : add_x;
            nxt_lo  = {cur_lo[WIDTH-2:0], fits};
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_hi    <= '0;
            acc_lo    <= '0;
            operand_b <= '0;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            div_mode  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (start) begin
                acc_hi    <= nxt_hi;
                acc_lo    <= nxt_lo;
                operand_b <= b;
                count     <= CW'(WIDTH - 1);
                busy      <= 1'b1;
`ifdef ALU_SEQ_DIV_EN
                div_mode  <= is_div;
`endif
            end else if (busy) begin
                acc_hi <= nxt_hi;
                acc_lo <= nxt_lo;
                count  <= count - CW'(1);
                if (count == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign res_hi = acc_hi;
    assign res_lo = acc_lo;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes: single-cycle ops plus iterative MULT/DIV.
// Define ALU_SEQ_DIV_EN to build the divider; otherwise DIV behaves as an unknown opcode.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opt,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             div_by_zero
);

    // Narrow datapaths do not have every bit of the b[6 +: SHW] field; missing bits read as zero.
    localparam int SH_AVAIL = ((WIDTH - 6) < SHW) ? (WIDTH - 6) : SHW;
    localparam logic [WIDTH-1:0] WIDTH_VAL = WIDTH'(WIDTH);

    alu_seq_state_t state;

    logic             accept;
    logic             is_iter;
    logic [SHW-1:0]   shamt;
    logic             var_oob;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] neg_b;
    logic [WIDTH-1:0] comb_out;
    logic [WIDTH-1:0] comb_hi;
    logic             comb_carry;
    logic             comb_dbz;

    logic             md_busy;
    logic             md_done;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;

    assign in_ready  = ((state == ST_IDLE) && !md_busy) || ((state == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_DONE);

    assign shamt   = SHW'(b[6 +: SH_AVAIL]);
    assign var_oob = (b >= WIDTH_VAL);
    assign sum     = a + b;
    assign diff    = a - b;
    assign neg_b   = -b;

`ifdef ALU_SEQ_DIV_EN
    assign is_iter = (opt == ALU_MULT) || ((opt == ALU_DIV) && (b != '0));
`else
    assign is_iter = (opt == ALU_MULT);
`endif

    // Results of every op that completes on the accept edge.
    always_comb begin
        comb_out   = '0;
        comb_hi    = '0;
        comb_carry = 1'b0;
        comb_dbz   = 1'b0;
        case (opt)
            ALU_ADD: begin
                comb_out   = sum;
                comb_carry = signed_overflow(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1]);
            end
            ALU_SUB: begin
                comb_out   = diff;
                comb_carry = signed_overflow(a[WIDTH-1], neg_b[WIDTH-1], diff[WIDTH-1]);
            end
            ALU_AND:  comb_out = a & b;
            ALU_OR:   comb_out = a | b;
            ALU_XOR:  comb_out = a ^ b;
            ALU_NOR:  comb_out = ~(a | b);
            ALU_SLL:  comb_out = a << shamt;
            ALU_SRL:  comb_out = a >> shamt;
            ALU_SRA:  comb_out = $signed(a) >>> shamt;
            ALU_SLLV: begin
                if (!var_oob) comb_out = a << b;
            end
            ALU_SRLV: begin
                if (!var_oob) comb_out = a >> b;
            end
            ALU_SRAV: begin
                if (!var_oob) comb_out = $signed(a) >>> b;
            end
            ALU_EQ:   comb_out = WIDTH'(a == b);
            ALU_NEQ:  comb_out = WIDTH'(a != b);
            ALU_LT:   comb_out = WIDTH'($signed(a) <  $signed(b));
            ALU_LE:   comb_out = WIDTH'($signed(a) <= $signed(b));
            ALU_GT:   comb_out = WIDTH'($signed(a) >  $signed(b));
            ALU_GE:   comb_out = WIDTH'($signed(a) >= $signed(b));
            ALU_LUI:  comb_out = {b[WIDTH/2-1:0], a[WIDTH/2-1:0]};
`ifdef ALU_SEQ_DIV_EN
            ALU_DIV: begin
                if (b == '0) begin
                    comb_out = '1;
                    comb_hi  = a;
                    comb_dbz = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (accept && is_iter),
`ifdef ALU_SEQ_DIV_EN
        .is_div (opt == ALU_DIV),
`endif
        .a      (a),
        .b      (b),
        .busy   (md_busy),
        .done   (md_done),
        .res_hi (md_hi),
        .res_lo (md_lo)
    );

    // Result registers only change on an accept of a single-cycle op or on
    // iterator completion, so they stay frozen for as long as DONE is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            out         <= '0;
            hi          <= '0;
            zero        <= 1'b0;
            negative    <= 1'b0;
            carry       <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        if (is_iter) begin
                            state <= ST_BUSY;
                        end else begin
                            state       <= ST_DONE;
                            out         <= comb_out;
                            hi          <= comb_hi;
                            zero        <= (comb_out == '0);
                            negative    <= comb_out[WIDTH-1];
                            carry       <= comb_carry;
                            div_by_zero <= comb_dbz;
                        end
                    end else if ((state == ST_DONE) && out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (md_done) begin
                        state       <= ST_DONE;
                        out         <= md_lo;
                        hi          <= md_hi;
                        zero        <= (md_lo == '0);
                        negative    <= md_lo[WIDTH-1];
                        carry       <= 1'b0;
                        div_by_zero <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning datapath width; legal values are 8..64 and must be even.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), meaning the shift-amount field width (derived, not overridden).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 opt  input  5  operation code, alu_op_t from alu_pkg.
REQ-008 a, b  input  WIDTH  operands.
REQ-009 out_valid  output  1  result registers hold a completed result.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 out  output  WIDTH  primary result: low product for MULT, quotient for DIV.
REQ-012 hi  output  WIDTH  high product for MULT, remainder for DIV, 0 for all other ops.
REQ-013 zero, negative, carry, div_by_zero  output  1 each  result flags, registered with out.

Function
REQ-014 SHALL be a three-state FSM: IDLE, BUSY, DONE.
REQ-015 in_ready SHALL be 1 in IDLE, or in DONE while out_ready=1; it SHALL be 0 otherwise.
REQ-016 Accept occurs when in_valid && in_ready; SHALL capture opt, a and b on the accept edge.
REQ-017 Single-cycle ops, DIV with b=0, and unknown opcodes SHALL go to DONE on the accept edge, giving out_valid 1 cycle after accept.
REQ-018 MULT and DIV with b!=0 SHALL go to BUSY, iterate for exactly WIDTH cycles, then enter DONE; out_valid rises WIDTH+1 cycles after accept.
REQ-019 In DONE, out_valid=1 and all outputs SHALL be held stable until out_ready=1.
REQ-020 If DONE && out_ready && in_valid on the same cycle, SHALL retire the old result and accept the new op on that edge (back-to-back; no bubble for single-cycle ops).
REQ-021 DONE && out_ready && !in_valid SHALL go to IDLE, with out_valid=0 on the next cycle.
REQ-022 ADD/SUB SHALL be modulo 2^WIDTH; carry = signed overflow (operands of equal sign and result sign differing; for SUB, test against the sign of -b).
REQ-023 MULT SHALL be unsigned shift-add, with {hi,out} = the full 2*WIDTH product.
REQ-024 DIV SHALL be unsigned restoring division; b=0 gives out=all ones, hi=a, div_by_zero=1.
REQ-025 Variable shifts SHALL shift by the full value of b (result 0 when b>=WIDTH); SH_AMOUNT shifts use b[6+SHW-1:6].
REQ-026 Comparisons SHALL be signed (EQ/NEQ bitwise) and give out=1 or 0.
REQ-027 LUI SHALL give {b[WIDTH/2-1:0], a[WIDTH/2-1:0]}.
REQ-028 Unknown opt SHALL give out=0.
REQ-029 zero = (out==0), negative = out[WIDTH-1]; carry and div_by_zero SHALL be 0 for any op not named in REQ-022/REQ-024.

Reset
REQ-030 While reset=1, independent of clk: state=IDLE, out_valid=0, out=hi=0, all flags 0, in_ready=1.
REQ-031 Reset during BUSY SHALL abort the op with no result emitted; the first accept after deassert behaves as from power-up.

Configuration
REQ-032 Macro ALU_SEQ_DIV_EN: when defined, DIV behaves per REQ-018/REQ-024.
REQ-033 Without ALU_SEQ_DIV_EN: no divider logic; DIV is treated as an unknown opcode (single-cycle, out=hi=0, div_by_zero=0); MULT is unaffected.

Structure
REQ-034 alu_pkg SHALL hold alu_op_t (5-bit enum, values identical to the existing ALU_* opcodes) and alu_seq_state_t.
REQ-035 Iterative multiply/divide SHALL live in one sub-module, alu_muldiv_iter (start/busy/done, shared WIDTH-bit adder); all other ops stay combinational in alu_seq.

Verification (WIDTH=32, DIV_EN defined unless noted)
REQ-036 ADD 0x7FFFFFFF+1 -> out=0x80000000, carry=1, negative=1, out_valid exactly 1 cycle after accept.
REQ-037 MULT 0xFFFFFFFF*2 -> out=0xFFFFFFFE, hi=1, out_valid 33 cycles after accept, in_ready=0 throughout BUSY.
REQ-038 DIV 100/7 -> out=14, hi=2 after 33 cycles; DIV 5/0 -> out=0xFFFFFFFF, hi=5, div_by_zero=1 after 1 cycle.
REQ-039 SUB 3-3 with out_ready held 0 for 5 cycles -> out=0, zero=1, stable all 5 cycles; then out_ready=1 with in_valid=1 (OR 1|2) -> new op accepted that edge, out=3 next cycle.
REQ-040 reset pulsed on cycle 10 of MULT -> out_valid=0 and in_ready=1 immediately; next ADD 2+2 -> out=4 after 1 cycle.
REQ-041 Without ALU_SEQ_DIV_EN: DIV 100/7 -> out=0, hi=0, div_by_zero=0, out_valid 1 cycle after accept.
